wait_state_memory: RTL and testbench
====================================

Name: wait_state_memory

Overview:
- Parametrised successor to the system main memory: a word-addressed RAM behind a four-phase RD/WR/ACK handshake with a configurable number of wait states.
- Adds the following behaviour:
  - address range checking with an error flag;
  - illegal-request (RD and WR together) detection;
  - a busy indication;
  - a read-data hold register.
- Sits between the control unit (RD/WR/ACK), BUS_A (address) and BUS_B (write data) of the datapath. Its read data feeds the BUS_C source mux.

Parameters:
- DATAWIDTH_BUS, 32, width of the data and address buses.
- ADDRWIDTH, 8, number of low address bits decoded. Upper bits must be zero.
- DEPTH, 256, number of words. Must satisfy 1 <= DEPTH <= 2^ADDRWIDTH.
- LATENCY, 2, wait states inserted before ACK. 0..15 are legal.

Ports:
- wait_state_memory_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- wait_state_memory_RESET_InHigh  in  1  asynchronous, active-high reset.
- wait_state_memory_RD_In  in  1  read request, level, held until ACK.
- wait_state_memory_WR_In  in  1  write request, level, held until ACK.
- wait_state_memory_ADDRESS_InBUS  in  DATAWIDTH_BUS  word address.
- wait_state_memory_data_InBUS  in  DATAWIDTH_BUS  write data.
- wait_state_memory_data_OutBUS  out  DATAWIDTH_BUS  registered read data.
- wait_state_memory_ACK_Out  out  1  transfer complete.
- wait_state_memory_ERR_Out  out  1  completed transfer was erroneous; valid while ACK is high.
- wait_state_memory_BUSY_Out  out  1  a transaction is in progress (WAIT or ACK state).

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - FSM to IDLE;
  - wait counter to 0;
  - data_OutBUS, ACK, ERR and BUSY to 0.
- The RAM array is not reset; its contents are undefined until written.
- FSM states are IDLE, WAIT and ACK.
- IDLE:
  - If RD or WR is sampled high, latch the address, data and request type, load the counter with LATENCY, set BUSY, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If the counter is nonzero, decrement it and stay in WAIT.
  - If the counter is 0, perform the access, set ACK, and go to ACK.
  - ACK therefore rises exactly LATENCY+1 edges after the sampling edge. With LATENCY=0, ACK rises on the next edge.
- ACK:
  - Hold ACK (and ERR, if set) high until RD and WR are both sampled low.
  - On that edge, clear ACK, ERR and BUSY, and return to IDLE.
  - A new request can be sampled no earlier than the edge after this.
- Access rules, applied on the WAIT->ACK edge using the latched values:
  - Read: data_OutBUS <= mem[addr]. The value holds until the next successful read or reset.
  - Write: mem[addr] <= latched data. data_OutBUS is unchanged.
  - Out-of-range: the address is >= DEPTH or any bit above ADDRWIDTH-1 is set. ERR=1, no write, data_OutBUS <= 0.
  - Illegal request: RD and WR both high when sampled. ERR=1, no access, data_OutBUS unchanged.
- Changes to ADDRESS, data_InBUS, RD or WR after the sampling edge do not affect the transfer in progress, except the final deassert that releases ACK.
- If the requester drops its request during WAIT, the transfer still completes. ACK then pulses for exactly one cycle, because the release condition is already met on the next edge.
- Reset mid-transaction:
  - Reset before the WAIT->ACK edge aborts the transfer; no memory write occurs.
  - A write already committed is kept.
- BUSY is high from the edge after sampling until the edge that returns the FSM to IDLE.

Test Plan:
- Reset, then idle: with RESET high, ACK=0, ERR=0, BUSY=0, data_OutBUS=0. After release, with RD=WR=0, all outputs stay 0 for 10 cycles.
- Write then read, LATENCY=2:
  - Write: WR with addr 0x05, data 0x0000_00A5. ACK rises 3 edges after sampling, with ERR=0.
  - Drop WR; ACK falls on the next edge.
  - Read: RD with addr 0x05. data_OutBUS=0x0000_00A5 at ACK.
- LATENCY=0 build: RD at addr 0x00 after writing 0x1234_5678. ACK and data_OutBUS=0x1234_5678 appear 1 edge after sampling.
- Range error, DEPTH=200:
  - WR at addr 0xC8 (200) -> ACK with ERR=1.
  - Then RD at 0xC8 -> ERR=1, data_OutBUS=0.
  - Then RD at 0x0000_0105 (bit 8 set) -> ERR=1.
- Illegal request: RD=WR=1 at addr 0x05 -> ERR=1 with ACK. A following read of 0x05 still returns 0x0000_00A5.
- Reset during WAIT: WR to addr 0x07 with data 0xDEAD_BEEF, LATENCY=4. Assert reset 2 cycles after sampling -> outputs cleared immediately. A later read of 0x07 returns the prior value, not 0xDEAD_BEEF.

Source files
------------

// File: rtl/wait_state_memory.sv
`default_nettype none
// ============================================================================
// Module   : wait_state_memory
// Purpose  : Word-addressed RAM behind a four-phase RD/WR/ACK handshake with
//            a configurable number of wait states. It checks the address
//            range, flags illegal RD+WR requests, reports BUSY and holds the
//            last read data.
// Revision : 1.0 - initial release
// ============================================================================
module wait_state_memory #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int DEPTH         = 256,
  parameter int LATENCY       = 2
) (
  input  logic                     wait_state_memory_CLOCK_50,
  input  logic                     wait_state_memory_RESET_InHigh,
  input  logic                     wait_state_memory_RD_In,
  input  logic                     wait_state_memory_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] wait_state_memory_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] wait_state_memory_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] wait_state_memory_data_OutBUS,
  output logic                     wait_state_memory_ACK_Out,
  output logic                     wait_state_memory_ERR_Out,
  output logic                     wait_state_memory_BUSY_Out
);

  // Index width of the RAM array; a single-word RAM still needs one bit.
  localparam int                 C_IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]         C_LAT   = LATENCY[3:0];
  localparam logic [ADDRWIDTH:0] C_DEPTH = (ADDRWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [3:0]               r_count;
  logic [DATAWIDTH_BUS-1:0] r_addr;
  logic [DATAWIDTH_BUS-1:0] r_wdata;
  logic                     r_isRd;
  logic                     r_isWr;
  logic [DATAWIDTH_BUS-1:0] r_rdata;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_busy;

  logic [DATAWIDTH_BUS-1:0] r_mem [0:DEPTH-1];

  logic              w_request;
  logic              w_doAccess;
  logic              w_illegal;
  logic              w_upperSet;
  logic              w_outOfRange;
  logic              w_memWe;
  logic [C_IDXW-1:0] w_memIdx;

  assign w_request = wait_state_memory_RD_In | wait_state_memory_WR_In;
  assign w_illegal = r_isRd & r_isWr;
  assign w_memIdx  = r_addr[C_IDXW-1:0];

  // Any address bit above the decoded field makes the access out of range.
  generate
    if (ADDRWIDTH < DATAWIDTH_BUS) begin : g_upperBits
      assign w_upperSet = |r_addr[DATAWIDTH_BUS-1:ADDRWIDTH];
    end else begin : g_noUpperBits
      assign w_upperSet = 1'b0;
    end
  endgenerate

  assign w_outOfRange = w_upperSet | ({1'b0, r_addr[ADDRWIDTH-1:0]} >= C_DEPTH);
  assign w_memWe      = w_doAccess & r_isWr & ~r_isRd & ~w_outOfRange;

  // Next-state decode; the access happens on the WAIT->ACK edge.
  always_comb begin
    w_nextState = r_state;
    w_doAccess  = 1'b0;
    case (r_state)
      S_IDLE: if (w_request) w_nextState = S_WAIT;
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_doAccess  = 1'b1;
          w_nextState = S_ACK;
        end
      end
      S_ACK:   if (!w_request) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State, request latches, wait counter and registered outputs.
  always_ff @(posedge wait_state_memory_CLOCK_50 or posedge wait_state_memory_RESET_InHigh) begin
    if (wait_state_memory_RESET_InHigh) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_isRd  <= 1'b0;
      r_isWr  <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_addr  <= wait_state_memory_ADDRESS_InBUS;
            r_wdata <= wait_state_memory_data_InBUS;
            r_isRd  <= wait_state_memory_RD_In;
            r_isWr  <= wait_state_memory_WR_In;
            r_count <= C_LAT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_ack <= 1'b1;
            r_err <= w_illegal | w_outOfRange;
            // Illegal requests leave the read register untouched.
            if (!w_illegal) begin
              if (w_outOfRange)  r_rdata <= '0;
              else if (r_isRd)   r_rdata <= r_mem[w_memIdx];
            end
          end
        end
        S_ACK: begin
          if (!w_request) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM array write port; contents are intentionally not reset.
  always_ff @(posedge wait_state_memory_CLOCK_50) begin
    if (w_memWe) r_mem[w_memIdx] <= r_wdata;
  end

  assign wait_state_memory_data_OutBUS = r_rdata;
  assign wait_state_memory_ACK_Out     = r_ack;
  assign wait_state_memory_ERR_Out     = r_err;
  assign wait_state_memory_BUSY_Out    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wait_state_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_wait_state_memory
// Purpose  : Directed bench for wait_state_memory. Three builds run side by
//            side: [0] LATENCY=2 DEPTH=200, [1] LATENCY=0 DEPTH=256,
//            [2] LATENCY=4 DEPTH=256.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wait_state_memory;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        ack  [3];
  logic        err  [3];
  logic        busy [3];

  int lat [3] = '{2, 0, 4};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wait_state_memory #(.DATAWIDTH_BUS(32), .ADDRWIDTH(8), .DEPTH(200), .LATENCY(2)) dutA (
    .wait_state_memory_CLOCK_50(clk), .wait_state_memory_RESET_InHigh(rst[0]),
    .wait_state_memory_RD_In(rd[0]), .wait_state_memory_WR_In(wr[0]),
    .wait_state_memory_ADDRESS_InBUS(addr[0]), .wait_state_memory_data_InBUS(din[0]),
    .wait_state_memory_data_OutBUS(dout[0]), .wait_state_memory_ACK_Out(ack[0]),
    .wait_state_memory_ERR_Out(err[0]), .wait_state_memory_BUSY_Out(busy[0]));

  wait_state_memory #(.DATAWIDTH_BUS(32), .ADDRWIDTH(8), .DEPTH(256), .LATENCY(0)) dutB (
    .wait_state_memory_CLOCK_50(clk), .wait_state_memory_RESET_InHigh(rst[1]),
    .wait_state_memory_RD_In(rd[1]), .wait_state_memory_WR_In(wr[1]),
    .wait_state_memory_ADDRESS_InBUS(addr[1]), .wait_state_memory_data_InBUS(din[1]),
    .wait_state_memory_data_OutBUS(dout[1]), .wait_state_memory_ACK_Out(ack[1]),
    .wait_state_memory_ERR_Out(err[1]), .wait_state_memory_BUSY_Out(busy[1]));

  wait_state_memory #(.DATAWIDTH_BUS(32), .ADDRWIDTH(8), .DEPTH(256), .LATENCY(4)) dutC (
    .wait_state_memory_CLOCK_50(clk), .wait_state_memory_RESET_InHigh(rst[2]),
    .wait_state_memory_RD_In(rd[2]), .wait_state_memory_WR_In(wr[2]),
    .wait_state_memory_ADDRESS_InBUS(addr[2]), .wait_state_memory_data_InBUS(din[2]),
    .wait_state_memory_data_OutBUS(dout[2]), .wait_state_memory_ACK_Out(ack[2]),
    .wait_state_memory_ERR_Out(err[2]), .wait_state_memory_BUSY_Out(busy[2]));

  // One full handshake on build i: ACK must rise exactly lat+1 edges after
  // sampling and fall on the edge after the request drops. Address and data
  // are scrambled after sampling to prove they were latched.
  task automatic runXfer(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic expErr, input logic chkData,
                         input logic [31:0] expData, input string name);
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
    @(posedge clk); #1;
    checks++;
    if (busy[i] !== 1'b1) begin errors++; $display("FAIL %s busy_after_sample got=%b exp=1", name, busy[i]); end
    checks++;
    if (ack[i] !== 1'b0) begin errors++; $display("FAIL %s ack_after_sample got=%b exp=0", name, ack[i]); end
    addr[i] = ~a; din[i] = ~d;
    for (int k = 0; k < lat[i]; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[i] !== 1'b0) begin errors++; $display("FAIL %s ack_early wait=%0d got=%b exp=0", name, k, ack[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (ack[i] !== 1'b1) begin errors++; $display("FAIL %s ack_rise got=%b exp=1", name, ack[i]); end
    checks++;
    if (err[i] !== expErr) begin errors++; $display("FAIL %s err got=%b exp=%b", name, err[i], expErr); end
    if (chkData) begin
      checks++;
      if (dout[i] !== expData) begin errors++; $display("FAIL %s data got=%h exp=%h", name, dout[i], expData); end
    end
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || err[i] !== 1'b0) begin
      errors++; $display("FAIL %s release got ack=%b busy=%b err=%b exp=000", name, ack[i], busy[i], err[i]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ack[i] !== 1'b0 || err[i] !== 1'b0 || busy[i] !== 1'b0 || dout[i] !== 32'h0) begin
        errors++; $display("FAIL reset_state dut=%0d got ack=%b err=%b busy=%b data=%h exp all 0", i, ack[i], err[i], busy[i], dout[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[0] !== 1'b0 || err[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 32'h0) begin
        errors++; $display("FAIL idle cycle=%0d got ack=%b err=%b busy=%b data=%h exp all 0", c, ack[0], err[0], busy[0], dout[0]);
      end
    end
  endtask

  task automatic test_write_read();
    runXfer(0, 1'b0, 1'b1, 32'h05, 32'h0000_00A5, 1'b0, 1'b1, 32'h0, "wr05");
    runXfer(0, 1'b1, 1'b0, 32'h05, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, "rd05");
  endtask

  task automatic test_latency0();
    runXfer(1, 1'b0, 1'b1, 32'h00, 32'h1234_5678, 1'b0, 1'b0, 32'h0, "lat0_wr00");
    runXfer(1, 1'b1, 1'b0, 32'h00, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "lat0_rd00");
  endtask

  task automatic test_range();
    runXfer(0, 1'b0, 1'b1, 32'hC7, 32'h0000_0C7C, 1'b0, 1'b0, 32'h0, "wr_last");
    runXfer(0, 1'b1, 1'b0, 32'hC7, 32'h0,         1'b0, 1'b1, 32'h0000_0C7C, "rd_last");
    runXfer(0, 1'b0, 1'b1, 32'hC8, 32'h0000_0BAD, 1'b1, 1'b0, 32'h0, "wr_oor");
    runXfer(0, 1'b1, 1'b0, 32'hC8, 32'h0,         1'b1, 1'b1, 32'h0, "rd_oor");
    runXfer(0, 1'b1, 1'b0, 32'h05, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, "rd05_again");
    runXfer(0, 1'b1, 1'b0, 32'h105, 32'h0,        1'b1, 1'b1, 32'h0, "rd_upper");
  endtask

  task automatic test_illegal();
    runXfer(0, 1'b1, 1'b0, 32'hC7, 32'h0,         1'b0, 1'b1, 32'h0000_0C7C, "rd_last2");
    runXfer(0, 1'b1, 1'b1, 32'h05, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0C7C, "illegal");
    runXfer(0, 1'b1, 1'b0, 32'h05, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, "rd05_post_illegal");
  endtask

  // Request dropped during WAIT: transfer completes and ACK pulses once.
  task automatic test_drop_early();
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 32'h05;
    @(posedge clk);
    @(negedge clk);
    rd[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack[0] !== 1'b0) begin errors++; $display("FAIL drop_early ack_before got=%b exp=0", ack[0]); end
    @(posedge clk); #1;
    checks++;
    if (ack[0] !== 1'b1 || dout[0] !== 32'h0000_00A5) begin
      errors++; $display("FAIL drop_early pulse got ack=%b data=%h exp ack=1 data=000000a5", ack[0], dout[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL drop_early end got ack=%b busy=%b exp 0 0", ack[0], busy[0]);
    end
  endtask

  task automatic test_reset_wait();
    runXfer(2, 1'b0, 1'b1, 32'h07, 32'h1111_1111, 1'b0, 1'b0, 32'h0, "lat4_wr07");
    runXfer(2, 1'b1, 1'b0, 32'h07, 32'h0,         1'b0, 1'b1, 32'h1111_1111, "lat4_rd07");
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h07; din[2] = 32'hDEAD_BEEF;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy[2] !== 1'b1 || ack[2] !== 1'b0) begin
      errors++; $display("FAIL rst_wait pre got busy=%b ack=%b exp 1 0", busy[2], ack[2]);
    end
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    checks++;
    if (ack[2] !== 1'b0 || err[2] !== 1'b0 || busy[2] !== 1'b0 || dout[2] !== 32'h0) begin
      errors++; $display("FAIL rst_wait clear got ack=%b err=%b busy=%b data=%h exp all 0", ack[2], err[2], busy[2], dout[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0; wr[2] = 1'b0;
    repeat (6) @(posedge clk);
    runXfer(2, 1'b1, 1'b0, 32'h07, 32'h0, 1'b0, 1'b1, 32'h1111_1111, "rd07_after_rst");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency0();
    test_range();
    test_illegal();
    test_drop_early();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
